// File: rtl/memo_xfer_engine_pkg.sv
// memo_xfer_engine shared types: FSM states and reduction mode codes.
// Optional saturation build: define MEMO_XFER_SAT_EN.
package memo_xfer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RD0,
    RD1,
    DONE
  } state_t;

  localparam logic [1:0] MODE_AUTO = 2'd0;
  localparam logic [1:0] MODE_SUM  = 2'd1;
  localparam logic [1:0] MODE_DIFF = 2'd2;
  localparam logic [1:0] MODE_MAX  = 2'd3;

endpackage

// File: rtl/memo_xfer_engine_if.sv
// Host-side bundle of memo_xfer_engine: control, load stream, B read port.
// master = host controller, slave = engine.
interface memo_xfer_engine_if #(
  parameter int W   = 8,
  parameter int AWB = 2
);
  logic           Start;
  logic [1:0]     Mode;
  logic [W-1:0]   DataInA;
  logic           InValid;
  logic           InReady;
  logic [AWB-1:0] RdAddrB;
  logic [W-1:0]   DataOutB;
  logic           Busy;
  logic           Done;
  logic           Ovf;

  modport master (
    output Start, Mode, DataInA, InValid, RdAddrB,
    input  InReady, DataOutB, Busy, Done, Ovf
  );

  modport slave (
    input  Start, Mode, DataInA, InValid, RdAddrB,
    output InReady, DataOutB, Busy, Done, Ovf
  );
endinterface

// File: rtl/memo_xfer_engine_pair_alu.sv
// memo_pair_alu: reduces one (first, second) pair to a single word.
// MEMO_XFER_SAT_EN selects saturating add/sub instead of wrapping.
module memo_pair_alu
  import memo_xfer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] f_i,
  input  logic [W-1:0] s_i,
  input  logic [1:0]   mode_i,
  output logic [W-1:0] result_o,
  output logic         ovf_o
);

  logic [W:0] sum_w;
  logic [W:0] dif_w;
  logic       s_gt;
  logic       do_add;
  logic       do_sub;

  assign sum_w = {1'b0, f_i} + {1'b0, s_i};
  assign dif_w = {1'b0, f_i} - {1'b0, s_i};
  assign s_gt  = s_i > f_i;

  // Pick the arithmetic the mode asks for; auto adds only when s > f.
  always_comb begin
    do_add = 1'b0;
    do_sub = 1'b0;
    case (mode_i)
      MODE_AUTO: begin
        do_add = s_gt;
        do_sub = !s_gt;
      end
      MODE_SUM:  do_add = 1'b1;
      MODE_DIFF: do_sub = 1'b1;
      default: ;
    endcase
  end

  // Form the result; the top bit of the widened add/sub is carry/borrow.
  always_comb begin
    result_o = s_gt ? s_i : f_i;
    ovf_o    = 1'b0;
    unique case (1'b1)
      do_add: begin
        ovf_o = sum_w[W];
`ifdef MEMO_XFER_SAT_EN
        result_o = sum_w[W] ? '1 : sum_w[W-1:0];
`else
        result_o = sum_w[W-1:0];
`endif
      end
      do_sub: begin
        ovf_o = dif_w[W];
`ifdef MEMO_XFER_SAT_EN
        result_o = dif_w[W] ? '0 : dif_w[W-1:0];
`else
        result_o = dif_w[W-1:0];
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memo_xfer_engine.sv
// memo_xfer_engine: stream-load A, reduce pairs of A into B, host handshake.
// Optional build macro MEMO_XFER_SAT_EN makes sum/diff saturate.
module memo_xfer_engine
  import memo_xfer_pkg::*;
#(
  parameter int W       = 8,
  parameter int DEPTH_A = 8
) (
  input logic clock,
  input logic Reset,
  memo_xfer_engine_if.slave xif
);

  localparam int DEPTH_B = DEPTH_A / 2;
  localparam int AWA     = $clog2(DEPTH_A);
  localparam int AWB     = (DEPTH_B > 1) ? $clog2(DEPTH_B) : 1;

  localparam logic [AWA-1:0] LD_LAST = AWA'(DEPTH_A - 1);
  localparam logic [AWB-1:0] PR_LAST = AWB'(DEPTH_B - 1);

  logic [W-1:0] mem_a [DEPTH_A];
  logic [W-1:0] mem_b [DEPTH_B];

  state_t         state_q, state_d;
  logic [AWA-1:0] ld_q, ld_d;
  logic [AWB-1:0] i_q, i_d;
  logic [1:0]     mode_q, mode_d;
  logic           ovf_q, ovf_d;
  logic [W-1:0]   hold_q, hold_d;

  logic           wa_en;
  logic           wb_en;
  logic [AWA-1:0] pa0;
  logic [AWA-1:0] pa1;
  logic [W-1:0]   alu_res;
  logic           alu_ovf;

  assign pa0 = AWA'({i_q, 1'b0});
  assign pa1 = AWA'({i_q, 1'b1});

  memo_pair_alu #(.W(W)) u_alu (
    .f_i      (hold_q),
    .s_i      (mem_a[pa1]),
    .mode_i   (mode_q),
    .result_o (alu_res),
    .ovf_o    (alu_ovf)
  );

  // State, counters, latched mode, sticky overflow and the first-operand hold.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q <= IDLE;
      ld_q    <= '0;
      i_q     <= '0;
      mode_q  <= '0;
      ovf_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      i_q     <= i_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
      hold_q  <= hold_d;
    end
  end

  // Memories keep their contents across reset.
  always_ff @(posedge clock) begin
    if (wa_en) mem_a[ld_q] <= xif.DataInA;
    if (wb_en) mem_b[i_q]  <= alu_res;
  end

  // Next-state and write enables: load A, then two cycles per pair.
  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    i_d     = i_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    hold_d  = hold_q;
    wa_en   = 1'b0;
    wb_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (xif.Start) begin
          state_d = LOAD;
          mode_d  = xif.Mode;
          ovf_d   = 1'b0;
          ld_d    = '0;
          i_d     = '0;
        end
      end
      LOAD: begin
        if (xif.InValid) begin
          wa_en = 1'b1;
          ld_d  = ld_q + AWA'(1);
          if (ld_q == LD_LAST) state_d = RD0;
        end
      end
      RD0: begin
        hold_d  = mem_a[pa0];
        state_d = RD1;
      end
      RD1: begin
        wb_en = 1'b1;
        ovf_d = ovf_q | alu_ovf;
        if (i_q == PR_LAST) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + AWB'(1);
          state_d = RD0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign xif.InReady  = (state_q == LOAD);
  assign xif.Busy     = (state_q == LOAD) || (state_q == RD0)
                     || (state_q == RD1);
  assign xif.Done     = (state_q == DONE);
  assign xif.Ovf      = ovf_q;
  assign xif.DataOutB = mem_b[xif.RdAddrB];

endmodule

// File: tb/tb_memo_xfer_engine.sv
// Bench for memo_xfer_engine: directed and random runs against a pairwise model.
// Build with MEMO_XFER_SAT_EN to expect saturating sum/diff.
module tb_memo_xfer_engine;

  localparam int W       = 8;
  localparam int DEPTH_A = 8;
  localparam int DEPTH_B = DEPTH_A / 2;
  localparam int AWB     = (DEPTH_B > 1) ? $clog2(DEPTH_B) : 1;

  logic clock;
  logic Reset;

  memo_xfer_engine_if #(.W(W), .AWB(AWB)) xif ();

  memo_xfer_engine #(.W(W), .DEPTH_A(DEPTH_A)) dut (
    .clock (clock),
    .Reset (Reset),
    .xif   (xif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk;
  int n_pass;
  int a_ref [DEPTH_A];
  int b_exp [DEPTH_B];
  bit ovf_exp;
  bit ovf_p0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic void ref_op(input int m, input int f, input int s,
                                 output int r, output bit o);
    int full;
    int t;
    bit add;
    bit sub;
    full = 1 << W;
    add  = (m == 1) || (m == 0 && s > f);
    sub  = (m == 2) || (m == 0 && s <= f);
    o    = 1'b0;
    if (add) begin
      t = f + s;
      o = t >= full;
`ifdef MEMO_XFER_SAT_EN
      r = o ? full - 1 : t;
`else
      r = o ? t - full : t;
`endif
    end else if (sub) begin
      t = f - s;
      o = t < 0;
`ifdef MEMO_XFER_SAT_EN
      r = o ? 0 : t;
`else
      r = o ? t + full : t;
`endif
    end else begin
      r = (f > s) ? f : s;
    end
  endfunction

  function automatic void model(input int m);
    bit o;
    ovf_exp = 1'b0;
    for (int p = 0; p < DEPTH_B; p++) begin
      ref_op(m, a_ref[2*p], a_ref[2*p+1], b_exp[p], o);
      if (p == 0) ovf_p0 = o;
      ovf_exp = ovf_exp | o;
    end
  endfunction

  task automatic run_xfer(input int m, input int gap_at,
                          input bit glitch, input int reset_at);
    int  n;
    bit  seen;
    model(m);
    xif.Start = 1'b1;
    xif.Mode  = 2'(m);
    @(posedge clock); #1;
    xif.Start = 1'b0;
    xif.Mode  = 2'($urandom_range(0, 3));
    chk("busy_start", xif.Busy, 1);
    for (int k = 0; k < DEPTH_A; k++) begin
      if (k == gap_at) begin
        xif.InValid = 1'b0;
        repeat (3) begin
          @(posedge clock); #1;
          chk("busy_gap", xif.Busy, 1);
        end
      end
      xif.InValid = 1'b1;
      xif.DataInA = W'(a_ref[k]);
      if (glitch && k == 2) begin
        xif.Start = 1'b1;
        xif.Mode  = ~2'(m);
      end
      @(posedge clock); #1;
      xif.Start = 1'b0;
    end
    xif.InValid = 1'b0;
    if (reset_at >= 0) begin
      repeat (reset_at) @(posedge clock);
      #1;
      chk("ovf_pre_rst", xif.Ovf, ovf_p0);
      Reset = 1'b1;
      @(posedge clock); #1;
      Reset = 1'b0;
      chk("rst_busy", xif.Busy, 0);
      chk("rst_ready", xif.InReady, 0);
      chk("rst_ovf", xif.Ovf, 0);
      seen = xif.Done;
      repeat (12) begin
        @(posedge clock); #1;
        seen = seen | xif.Done;
      end
      chk("rst_no_done", seen, 0);
      return;
    end
    n    = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      @(posedge clock); #1;
      n++;
      seen = xif.Done;
    end
    chk("done_latency", n, DEPTH_A);
    chk("done_busy", xif.Busy, 0);
    chk("ovf", xif.Ovf, ovf_exp);
    for (int j = 0; j < DEPTH_B; j++) begin
      xif.RdAddrB = AWB'(j);
      #1;
      chk($sformatf("b%0d", j), xif.DataOutB, b_exp[j]);
    end
    @(posedge clock); #1;
    chk("done_pulse", xif.Done, 0);
  endtask

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    Reset       = 1'b1;
    xif.Start   = 1'b0;
    xif.Mode    = '0;
    xif.DataInA = '0;
    xif.InValid = 1'b0;
    xif.RdAddrB = '0;
    repeat (2) @(posedge clock);
    #1;
    Reset = 1'b0;
    chk("rst_inready", xif.InReady, 0);
    chk("rst_busy0", xif.Busy, 0);
    chk("rst_done0", xif.Done, 0);
    chk("rst_ovf0", xif.Ovf, 0);

    for (int k = 0; k < DEPTH_A; k++) a_ref[k] = k + 1;
    run_xfer(0, -1, 1'b0, -1);
    run_xfer(0, 3, 1'b1, -1);
    for (int k = 0; k < DEPTH_A; k++) a_ref[k] = DEPTH_A - k;
    run_xfer(0, -1, 1'b0, -1);

    for (int k = 0; k < DEPTH_A; k++) a_ref[k] = 0;
    a_ref[0] = 200;
    a_ref[1] = 100;
    run_xfer(1, -1, 1'b0, -1);
    a_ref[0] = 1;
    a_ref[1] = 2;
    run_xfer(2, -1, 1'b0, -1);
    a_ref[0] = 9;
    a_ref[1] = 4;
    run_xfer(3, -1, 1'b0, -1);

    a_ref[0] = 200;
    a_ref[1] = 100;
    run_xfer(1, -1, 1'b0, 3);
    for (int k = 0; k < DEPTH_A; k++) a_ref[k] = k + 1;
    run_xfer(0, -1, 1'b0, -1);

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < DEPTH_A; k++) a_ref[k] = $urandom_range(0, 255);
      run_xfer($urandom_range(0, 3),
               (r % 2 == 1) ? $urandom_range(1, DEPTH_A - 1) : -1,
               r[2], -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
